// File: rtl/iir_sched_pkg.sv
// Shared definitions for the IIR core scheduler: FSM encoding,
// coefficient register addresses and the default core latency.
package iir_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CRST     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_WAIT_IN  = 3'd3,
        ST_ISSUE    = 3'd4,
        ST_WAIT_LAT = 3'd5,
        ST_DRAIN    = 3'd6
    } state_t;

    localparam logic [2:0] ADDR_A1 = 3'd0;
    localparam logic [2:0] ADDR_A2 = 3'd1;
    localparam logic [2:0] ADDR_B0 = 3'd2;
    localparam logic [2:0] ADDR_B1 = 3'd3;
    localparam logic [2:0] ADDR_B2 = 3'd4;

    localparam int NUM_COEF     = 5;
    localparam int CORE_LAT_DEF = 8;

endpackage

// File: rtl/iir_sched_fifo.sv
// Two-entry, 8-bit output buffer between the IIR core and the m_* stream.
// The head is presented as zero while empty so the output bus is quiet.
module iir_sched_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    logic [7:0] mem_q [2];
    logic [7:0] mem_d [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       do_push;
    logic       do_pop;

    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);
    assign count    = cnt_q;
    assign pop_data = empty ? 8'h00 : mem_q[rd_q];

    // Next-state pointers and storage; a push into a full buffer is only taken alongside a pop.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
        end
        if (do_pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    // Buffer state registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= 8'h00;
            mem_q[1] <= 8'h00;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iir_sched.sv
// Scheduler for a shared IIR core: resets and loads the core with the five
// coefficients, then feeds one sample at a time, waits the fixed core
// latency and buffers each result in a 2-entry output FIFO.
module iir_sched
    import iir_sched_pkg::*;
#(
    parameter int CORE_LAT = CORE_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        go,
    input  logic [7:0]  nsamp,
    output logic        busy,
    output logic        done,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic        m_ready,
    output logic        core_rst,
    output logic        core_iir_start,
    output logic        core_start,
    output logic [15:0] core_params,
    output logic [7:0]  core_din,
    input  logic [7:0]  core_dout
);

    logic [15:0] coef_q [NUM_COEF];
    logic [15:0] coef_d [NUM_COEF];

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  lat_q, lat_d;
    logic [2:0]  ld_idx_q, ld_idx_d;
    logic        done_q, done_d;
    logic        core_rst_q, core_rst_d;
    logic        core_iir_start_q, core_iir_start_d;
    logic        core_start_q, core_start_d;
    logic [15:0] core_params_q, core_params_d;
    logic [7:0]  core_din_q, core_din_d;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  fifo_count;

    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign s_ready        = (state_q == ST_WAIT_IN) && !fifo_full;
    assign m_valid        = !fifo_empty;
    assign fifo_pop       = m_valid && m_ready;
    assign fifo_push      = (state_q == ST_WAIT_LAT) && (lat_q == 4'd0);
    assign core_rst       = core_rst_q;
    assign core_iir_start = core_iir_start_q;
    assign core_start     = core_start_q;
    assign core_params    = core_params_q;
    assign core_din       = core_din_q;

    iir_sched_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (core_dout),
        .pop       (fifo_pop),
        .pop_data  (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Coefficient writes are accepted only while idle and only to addresses a1..b2.
    always_comb begin
        coef_d = coef_q;
        if (cfg_we && (state_q == ST_IDLE) && (cfg_addr <= ADDR_B2)) begin
            coef_d[cfg_addr] = cfg_wdata;
        end
    end

    // Run sequencing; core outputs are derived from the next state so they come straight from flops.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        ld_idx_d   = ld_idx_q;
        done_d     = 1'b0;
        core_din_d = core_din_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    cnt_d   = nsamp;
                    state_d = ST_CRST;
                end
            end
            ST_CRST: begin
                ld_idx_d = 3'd0;
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                if (ld_idx_q == 3'(NUM_COEF - 1)) begin
                    state_d = (cnt_q == 8'd0) ? ST_DRAIN : ST_WAIT_IN;
                end else begin
                    ld_idx_d = ld_idx_q + 3'd1;
                end
            end
            ST_WAIT_IN: begin
                if (s_valid && s_ready) begin
                    core_din_d = s_data;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Counting down to zero lands the push on the edge ending cycle T+CORE_LAT.
                lat_d   = 4'(CORE_LAT - 1);
                state_d = ST_WAIT_LAT;
            end
            ST_WAIT_LAT: begin
                if (lat_q == 4'd0) begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? ST_DRAIN : ST_WAIT_IN;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            ST_DRAIN: begin
                if (fifo_count == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        core_rst_d       = (state_d == ST_CRST);
        core_iir_start_d = (state_d == ST_LOAD) && (ld_idx_d == 3'd0);
        core_start_d     = (state_d == ST_ISSUE);
        core_params_d    = (state_d == ST_LOAD) ? coef_q[ld_idx_d] : 16'h0000;
    end

    // Coefficient registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                coef_q[i] <= 16'h0000;
            end
        end else begin
            coef_q <= coef_d;
        end
    end

    // FSM state, counters and registered core-drive outputs; reset holds the core in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 8'd0;
            lat_q            <= 4'd0;
            ld_idx_q         <= 3'd0;
            done_q           <= 1'b0;
            core_rst_q       <= 1'b1;
            core_iir_start_q <= 1'b0;
            core_start_q     <= 1'b0;
            core_params_q    <= 16'h0000;
            core_din_q       <= 8'h00;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            lat_q            <= lat_d;
            ld_idx_q         <= ld_idx_d;
            done_q           <= done_d;
            core_rst_q       <= core_rst_d;
            core_iir_start_q <= core_iir_start_d;
            core_start_q     <= core_start_d;
            core_params_q    <= core_params_d;
            core_din_q       <= core_din_d;
        end
    end

endmodule

// File: tb/tb_iir_sched.sv
// Directed bench for iir_sched with a fixed-latency core model
// (core_dout = din ^ 0x1A, valid only in cycle T+8).
module tb_iir_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        go;
    logic [7:0]  nsamp;
    logic        busy, done;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        core_rst, core_iir_start, core_start;
    logic [15:0] core_params;
    logic [7:0]  core_din;
    logic [7:0]  core_dout;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_coef [5];

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
        bit         chk_load;
    } vec_t;
    vec_t vec [5];

    iir_sched #(.CORE_LAT(8)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .go(go), .nsamp(nsamp), .busy(busy), .done(done),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .core_rst(core_rst), .core_iir_start(core_iir_start), .core_start(core_start),
        .core_params(core_params), .core_din(core_din), .core_dout(core_dout)
    );

    always #5 clk = ~clk;

    // Core model: result is only meaningful in the cycle CORE_LAT after core_start.
    int         cyc = 100;
    logic [7:0] din_l = 8'h00;
    always @(posedge clk) begin
        if (core_start) begin
            cyc   <= 1;
            din_l <= core_din;
        end else if (cyc < 100) begin
            cyc <= cyc + 1;
        end
    end
    assign core_dout = (cyc == 8) ? (din_l ^ 8'h1A) : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_cfg(input logic [2:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // Starts a run; returns in the last LOAD cycle.
    task automatic start_run(input logic [7:0] n, input bit chk);
        go = 1'b1; nsamp = n;
        tick();
        go = 1'b0;
        if (chk) begin
            check("crst_core_rst", core_rst, 1);
            check("crst_busy", busy, 1);
            check("crst_params", core_params, 0);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            if (chk) begin
                check($sformatf("load%0d_params", i), core_params, exp_coef[i]);
                check($sformatf("load%0d_iir_start", i), core_iir_start, (i == 0));
                check($sformatf("load%0d_core_rst", i), core_rst, 0);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic run_one(input logic [7:0] din, input logic [7:0] exp, input bit chk);
        int w;
        int lat;
        start_run(8'd1, chk);
        tick();
        check("post_load_params", core_params, 0);
        w = 0;
        while (!s_ready && w < 10) begin tick(); w++; end
        check("s_ready_up", s_ready, 1);
        s_valid = 1'b1; s_data = din;
        tick();
        s_valid = 1'b0;
        check("issue_core_start", core_start, 1);
        check("issue_core_din", core_din, din);
        check("issue_s_ready", s_ready, 0);
        lat = 0;
        while (!m_valid && lat < 30) begin
            tick(); lat++;
            if (lat == 1) check("core_start_one_cycle", core_start, 0);
        end
        check("latency_to_m_valid", lat, 9);
        check("m_data", m_data, exp);
        check("core_din_held", core_din, din);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        w = 0;
        while (!done && w < 10) begin tick(); w++; end
        check("done_pulse", done, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fi, oi, dn, sr, mv, n;
        logic [7:0] smp [4];
        logic [7:0] res [4];

        vec[0] = '{8'h40, 8'h5A, 1'b1};
        vec[1] = '{8'h00, 8'h1A, 1'b0};
        vec[2] = '{8'hFF, 8'hE5, 1'b0};
        vec[3] = '{8'h1A, 8'h00, 1'b0};
        vec[4] = '{8'h81, 8'h9B, 1'b0};
        smp = '{8'h10, 8'h20, 8'h30, 8'h40};
        res = '{8'h0A, 8'h3A, 8'h2A, 8'h5A};

        reset = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 16'h0;
        go = 1'b0; nsamp = 8'd0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;

        // Reset held three cycles.
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_iir_start", core_iir_start, 0);
        check("rst_core_start", core_start, 0);
        check("rst_m_data", m_data, 0);
        check("rst_core_params", core_params, 0);
        check("rst_core_din", core_din, 0);
        check("rst_core_rst", core_rst, 1);
        reset = 1'b0;
        tick();
        check("rel_core_rst", core_rst, 0);
        check("rel_busy", busy, 0);

        // Program coefficients; address 5 must not land anywhere.
        write_cfg(3'd0, 16'h1111);
        write_cfg(3'd1, 16'h2222);
        write_cfg(3'd2, 16'h3333);
        write_cfg(3'd3, 16'h4444);
        write_cfg(3'd4, 16'h5555);
        write_cfg(3'd5, 16'hDEAD);
        exp_coef = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

        // Single-sample runs from the vector table.
        for (int i = 0; i < 5; i++) begin
            run_one(vec[i].din, vec[i].exp, vec[i].chk_load);
        end

        // nsamp=0 run with a coefficient write attempted while busy.
        start_run(8'd0, 1'b1);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'hBEEF;
        sr = 0; dn = 0;
        for (int c = 0; c < 20; c++) begin
            if (s_ready) sr++;
            if (done) dn++;
            tick();
            cfg_we = 1'b0;
        end
        check("nsamp0_s_ready_never", sr, 0);
        check("nsamp0_done_count", dn, 1);
        check("nsamp0_idle", busy, 0);

        // Coefficients must be unchanged by the write during the run.
        run_one(8'h55, 8'h4F, 1'b1);

        // nsamp=4 with backpressure, then release.
        start_run(8'd4, 1'b0);
        tick();
        fi = 0; oi = 0; dn = 0;
        for (int c = 0; c < 60; c++) begin
            s_valid = (fi < 4);
            s_data  = (fi < 4) ? smp[fi] : 8'h00;
            if (s_valid && s_ready) fi++;
            if (done) dn++;
            tick();
        end
        check("bp_accepted", fi, 2);
        check("bp_s_ready_low", s_ready, 0);
        check("bp_m_valid", m_valid, 1);
        check("bp_head", m_data, 8'h0A);
        m_ready = 1'b1;
        n = 0;
        while (n < 300 && !(dn > 0 && oi >= 4)) begin
            s_valid = (fi < 4);
            s_data  = (fi < 4) ? smp[fi] : 8'h00;
            if (m_valid) begin
                if (oi < 4) check($sformatf("bp_out%0d", oi), m_data, res[oi]);
                else check("bp_extra_output", m_data, 8'hxx);
                oi++;
            end
            if (s_valid && s_ready) fi++;
            if (done) dn++;
            tick();
            n++;
        end
        s_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (done) dn++;
            if (m_valid) oi++;
            tick();
        end
        m_ready = 1'b0;
        check("bp_out_count", oi, 4);
        check("bp_done_count", dn, 1);

        // Reset while the core result is in flight.
        start_run(8'd1, 1'b0);
        tick();
        n = 0;
        while (!s_ready && n < 10) begin tick(); n++; end
        s_valid = 1'b1; s_data = 8'h77;
        tick();
        s_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_m_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_core_rst", core_rst, 1);
        check("abort_done", done, 0);
        mv = 0; dn = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (m_valid) mv++;
            if (done) dn++;
        end
        check("abort_no_result", mv, 0);
        check("abort_no_done", dn, 0);

        // Coefficients were cleared by the reset.
        exp_coef = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        start_run(8'd0, 1'b1);
        n = 0;
        while (!done && n < 10) begin tick(); n++; end
        check("cleared_run_done", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
